pt4_macrocell_bank: RTL and testbench
=====================================

Name: pt4_macrocell_bank

Overview:
- Parametrised register bank of CELLS macrocell flip-flops.
- Each cell's product-term-4 (PT4) routing selects either global-clock operation with a clock enable, or PT4-clock operation.
- PT4-clock operation is implemented as a synchronised rising-edge enable in the gclk domain, so the bank stays single-clock.
- Adds D/T/bypass flip-flop modes, synchronous preset and asynchronous reset; sits between the product-term array and the output/feedback muxes.

Parameters:
- CELLS, 8, number of macrocells in the bank.
- RESET_VAL, {CELLS{1'b0}}, q value loaded by ar, one bit per cell.
- SYNC_STAGES, 2, depth (≥1) of the PT4-clock synchroniser chain per cell.

Ports:
- gclk  input  1  global clock; all state updates on its rising edge.
- ar  input  1  asynchronous reset, active-high.
- pt4_mux  input  CELLS  per-cell PT4 usage select.
- pt4_func_mux  input  CELLS  per-cell clock source: 0 = gclk with enable, 1 = PT4 clock.
- ff_mode  input  2*CELLS  per-cell mode, cell i at [2i+1:2i]: 00 D, 01 T, 10 bypass, 11 reserved (behaves as D).
- ce  input  CELLS  per-cell PT4 product-term signal.
- d  input  CELLS  per-cell data term.
- sp  input  CELLS  per-cell synchronous preset, active-high.
- q  output  CELLS  per-cell macrocell output.
- ffen  output  CELLS  per-cell effective enable, exported for observation.

Behaviour:
- Reset (ar=1, asynchronous): q register ← RESET_VAL; all synchroniser stages and the edge-history flop ← 0.
  - q output = RESET_VAL[i], except cells in bypass mode, where q = d.
  - ffen follows the combinational rules below.
- pt4clk[i] = pt4_mux[i] ? ce[i] : 1.
- Synchroniser:
  - s[0] ← pt4clk; s[k] ← s[k-1]; hist ← s[SYNC_STAGES-1].
  - The chain always runs, regardless of pt4_func_mux.
- pulse[i] = s[SYNC_STAGES-1] & ~hist.
- Effective enable (combinational):
  - pt4_func_mux=1: ffen = pulse.
  - pt4_func_mux=0 and pt4_mux=1: ffen = 1.
  - pt4_func_mux=0 and pt4_mux=0: ffen = ce.
- Latency, PT4-clock mode: pt4clk first sampled high at edge n gives a register update at edge n+SYNC_STAGES. This is exactly one update per low→high transition.
  - A high pulse shorter than one gclk period between edges is not required to be seen.
  - pt4clk held high across reset release counts as a rising edge: one update at edge SYNC_STAGES after release.
- Register update at each gclk rising edge, priority high to low:
  - sp=1: register ← 1, regardless of ffen and mode.
  - ffen=1, mode D/reserved/bypass: register ← d.
  - ffen=1, mode T: register ← register ^ d.
  - otherwise: hold.
- Output: q = d combinationally in bypass mode; otherwise q = register.
  - In bypass, the register keeps tracking, so leaving bypass shows the last enabled d with no extra cycle.
- Configuration inputs are static in normal use. If changed at run time, the change takes effect on the next edge; no state is flushed.
  - Switching pt4_func_mux 0→1 while the chain holds a pending 0→1 transition yields that pulse.
- Cells are fully independent; no cross-cell interaction.
- Widths are exact; no arithmetic beyond XOR.

Test Plan:
1. D mode, gclk source, pt4_mux=0, ce=1, d=1 → q=1 after one edge; then ce=0, d=0 for 5 edges → q stays 1.
2. Gclk source with pt4_mux=1, ce=0, d toggling 1,0,1 → q follows d each edge (ffen=1).
3. PT4-clock mode, SYNC_STAGES=2, pt4_mux=1, d=1, ce rises before edge 0 and stays high 6 edges → q=0 through edge 1, q=1 after edge 2; exactly one pulse, ffen high for one cycle only.
4. T mode, PT4 clock, d=1, ce toggles high 2 / low 2 cycles for 3 periods → q toggles 3 times, ending at 1 from RESET_VAL=0.
5. sp=1 with ffen=0 → q=1 next edge; sp=1 with ffen=1, d=0 → q=1 (preset wins).
6. ar asserted mid-cycle → q=RESET_VAL immediately without a clock edge. With ce held high through release, PT4 mode, d=1 → q=1 at the 2nd edge after release. Bypass cell tracks d throughout reset.

Source files
------------

// File: rtl/pt4_macrocell_bank.sv
// pt4_macrocell_bank: a bank of macrocell flip-flops between the product-term
// array and the output/feedback muxes. Each cell either runs on gclk with a
// clock enable, or on a PT4-derived clock. The PT4 clock is synchronised into
// the gclk domain and turned into a one-cycle rising-edge enable, so the whole
// bank stays on a single clock.
module pt4_macrocell_bank #(
    parameter int               CELLS       = 8,
    parameter logic [CELLS-1:0] RESET_VAL   = {CELLS{1'b0}},
    parameter int               SYNC_STAGES = 2
) (
    input  logic                 gclk,
    input  logic                 ar,
    input  logic [CELLS-1:0]     pt4_mux,
    input  logic [CELLS-1:0]     pt4_func_mux,
    input  logic [2*CELLS-1:0]   ff_mode,
    input  logic [CELLS-1:0]     ce,
    input  logic [CELLS-1:0]     d,
    input  logic [CELLS-1:0]     sp,
    output logic [CELLS-1:0]     q,
    output logic [CELLS-1:0]     ffen
);

    localparam logic [1:0] MODE_D      = 2'b00;
    localparam logic [1:0] MODE_T      = 2'b01;
    localparam logic [1:0] MODE_BYPASS = 2'b10;

    // Per-cell PT4 clock before synchronisation; tied high when PT4 is unused.
    logic [CELLS-1:0]                  pt4clk;
    // Synchroniser chain, stage 0 is closest to the PT4 input.
    logic [SYNC_STAGES-1:0][CELLS-1:0] sync_q;
    // Previous value of the last synchroniser stage, for edge detection.
    logic [CELLS-1:0]                  hist_q;
    logic [CELLS-1:0]                  pulse;
    logic [CELLS-1:0]                  reg_q;
    logic [CELLS-1:0]                  reg_d;

    assign pulse = sync_q[SYNC_STAGES-1] & ~hist_q;

    // Shift the PT4 clock through the synchroniser every gclk edge, whatever
    // the clock-source select says, so switching sources later sees history.
    always_ff @(posedge gclk or posedge ar) begin
        if (ar) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
            hist_q <= '0;
        end else begin
            sync_q[0] <= pt4clk;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Macrocell storage; ar forces the power-on pattern without a clock.
    always_ff @(posedge gclk or posedge ar) begin
        if (ar) begin
            reg_q <= RESET_VAL;
        end else begin
            reg_q <= reg_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < CELLS; gi++) begin : g_cell
            logic [1:0] mode;
            logic       loaded;

            assign mode = ff_mode[2*gi +: 2];

            assign pt4clk[gi] = pt4_mux[gi] ? ce[gi] : 1'b1;

            // PT4 clock mode uses the synchronised edge; otherwise PT4 either
            // acts as the clock enable or, when unused, the enable is forced.
            assign ffen[gi] = pt4_func_mux[gi] ? pulse[gi]
                                               : (pt4_mux[gi] | ce[gi]);

            // T mode toggles on d; D, bypass and the reserved code all load d.
            assign loaded = (mode == MODE_T) ? (reg_q[gi] ^ d[gi]) : d[gi];

            // Preset overrides everything, including a disabled cell.
            assign reg_d[gi] = sp[gi]   ? 1'b1   :
                               ffen[gi] ? loaded : reg_q[gi];

            // Bypass shows d directly while the register keeps tracking it.
            assign q[gi] = (mode == MODE_BYPASS) ? d[gi] : reg_q[gi];

            // Mode code MODE_D is the default arm of the decode above.
            logic unused_mode_d;
            assign unused_mode_d = (mode == MODE_D);
        end
    endgenerate

endmodule

// File: tb/tb_pt4_macrocell_bank.sv
// Testbench for pt4_macrocell_bank: directed scenarios followed by random
// traffic, all checked against a per-cell behavioural model.
module tb_pt4_macrocell_bank;

    localparam int               CELLS = 8;
    localparam int               S     = 2;
    localparam logic [CELLS-1:0] RV    = 8'h5A;

    logic                 gclk = 1'b0;
    logic                 ar;
    logic [CELLS-1:0]     pt4_mux, pt4_func_mux, ce, d, sp;
    logic [2*CELLS-1:0]   ff_mode;
    logic [CELLS-1:0]     q, ffen;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: register contents and, per cell, the PT4 clock values
    // sampled at the most recent S+1 edges (index 0 = latest edge).
    logic [CELLS-1:0] mreg;
    logic             samp [CELLS][S+1];

    always #5 gclk = ~gclk;

    pt4_macrocell_bank #(
        .CELLS       (CELLS),
        .RESET_VAL   (RV),
        .SYNC_STAGES (S)
    ) dut (
        .gclk         (gclk),
        .ar           (ar),
        .pt4_mux      (pt4_mux),
        .pt4_func_mux (pt4_func_mux),
        .ff_mode      (ff_mode),
        .ce           (ce),
        .d            (d),
        .sp           (sp),
        .q            (q),
        .ffen         (ffen)
    );

    function automatic logic [1:0] mode_of(int i);
        return ff_mode[2*i +: 2];
    endfunction

    function automatic logic m_pt4clk(int i);
        return pt4_mux[i] ? ce[i] : 1'b1;
    endfunction

    // A low-to-high transition first sampled at edge n fires at edge n+S:
    // before edge t, the sample from edge t-S is high and from t-S-1 is low.
    function automatic logic m_ffen(int i);
        if (pt4_func_mux[i]) return samp[i][S-1] & ~samp[i][S];
        if (pt4_mux[i])      return 1'b1;
        return ce[i];
    endfunction

    function automatic logic [CELLS-1:0] m_ffen_vec();
        logic [CELLS-1:0] v;
        for (int i = 0; i < CELLS; i++) v[i] = m_ffen(i);
        return v;
    endfunction

    function automatic logic [CELLS-1:0] m_q_vec();
        logic [CELLS-1:0] v;
        for (int i = 0; i < CELLS; i++) v[i] = (mode_of(i) == 2'b10) ? d[i] : mreg[i];
        return v;
    endfunction

    task automatic m_reset();
        mreg = RV;
        for (int i = 0; i < CELLS; i++)
            for (int k = 0; k <= S; k++) samp[i][k] = 1'b0;
    endtask

    task automatic m_edge();
        for (int i = 0; i < CELLS; i++) begin
            if (sp[i])             mreg[i] = 1'b1;
            else if (m_ffen(i))    mreg[i] = (mode_of(i) == 2'b01) ? (mreg[i] ^ d[i]) : d[i];
            for (int k = S; k > 0; k--) samp[i][k] = samp[i][k-1];
            samp[i][0] = m_pt4clk(i);
        end
    endtask

    task automatic check(input string tag, input logic [CELLS-1:0] obs, input logic [CELLS-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Check combinational outputs against the model, then take one edge.
    task automatic cycle(input string tag);
        #1;
        check($sformatf("%s q", tag), q, m_q_vec());
        check($sformatf("%s ffen", tag), ffen, m_ffen_vec());
        @(posedge gclk);
        if (ar) m_reset();
        else    m_edge();
        #1;
    endtask

    task automatic cfg(input logic func, input logic mux, input logic [1:0] mode);
        pt4_func_mux = {CELLS{func}};
        pt4_mux      = {CELLS{mux}};
        ff_mode      = {CELLS{mode}};
    endtask

    initial begin
        ar = 1'b1;
        cfg(1'b0, 1'b0, 2'b00);
        ce = '0; d = '0; sp = '0;
        m_reset();
        cycle("reset");
        cycle("reset");
        ar = 1'b0;

        // 1: D mode with gclk enable, then enable dropped.
        ce = '1; d = '1;
        cycle("t1 load");
        check("t1 loaded", q, '1);
        ce = '0; d = '0;
        for (int n = 0; n < 5; n++) cycle("t1 hold");
        check("t1 held", q, '1);

        // 2: PT4 used but gclk source -> enable forced high.
        cfg(1'b0, 1'b1, 2'b00);
        ce = '0;
        d = '1; cycle("t2"); check("t2 d1", q, '1);
        d = '0; cycle("t2"); check("t2 d0", q, '0);
        d = '1; cycle("t2"); check("t2 d1b", q, '1);

        // 3: PT4-clock mode, single rising edge on ce.
        cfg(1'b0, 1'b0, 2'b00); ce = '1; d = '0;
        cycle("t3 clear");
        cfg(1'b1, 1'b1, 2'b00); ce = '0;
        for (int n = 0; n < 4; n++) cycle("t3 settle");
        ce = '1; d = '1;
        cycle("t3 e0"); check("t3 q e0", q, '0);
        cycle("t3 e1"); check("t3 q e1", q, '0);
        check("t3 pulse", ffen, '1);
        cycle("t3 e2"); check("t3 q e2", q, '1);
        check("t3 pulse gone", ffen, '0);
        for (int n = 0; n < 4; n++) cycle("t3 high");

        // 4: T mode on PT4 clock, three ce periods -> three toggles.
        cfg(1'b0, 1'b0, 2'b00); ce = '1; d = '0;
        cycle("t4 clear");
        cfg(1'b1, 1'b1, 2'b00); ce = '0;
        for (int n = 0; n < 3; n++) cycle("t4 settle");
        check("t4 start", q, '0);
        ff_mode = {CELLS{2'b01}}; d = '1;
        for (int p = 0; p < 3; p++) begin
            ce = '1; cycle("t4 hi"); cycle("t4 hi");
            ce = '0; cycle("t4 lo"); cycle("t4 lo");
        end
        for (int n = 0; n < 3; n++) cycle("t4 tail");
        check("t4 end", q, '1);

        // 5: synchronous preset.
        cfg(1'b0, 1'b0, 2'b00); ce = '1; d = '0;
        cycle("t5 clear");
        ce = '0; sp = '1;
        cycle("t5 sp noen"); check("t5 sp noen", q, '1);
        ce = '1; d = '0;
        cycle("t5 sp en"); check("t5 sp en", q, '1);
        sp = '0;
        cycle("t5 release"); check("t5 release", q, '0);

        // 6: asynchronous reset mid-cycle, PT4 high across release, bypass cell 7.
        cfg(1'b1, 1'b1, 2'b00); ff_mode[2*(CELLS-1) +: 2] = 2'b10;
        ce = '1; d = '1;
        cycle("t6 pre");
        #2 ar = 1'b1; m_reset();
        #1 check("t6 async", q, RV | 8'h80);
        cycle("t6 rst");
        d = 8'h7F;
        cycle("t6 rst bypass");
        check("t6 bypass low", q, RV & 8'h7F);
        d = '1;
        cycle("t6 rst");
        ar = 1'b0;
        // Edge 0 is the first edge after release.
        cycle("t6 e0"); check("t6 e0", q[0], 1'b0);
        cycle("t6 e1"); check("t6 e1", q[0], 1'b0);
        cycle("t6 e2"); check("t6 e2", q[0], 1'b1);
        for (int n = 0; n < 3; n++) cycle("t6 after");

        // Random traffic, including run-time config changes and resets.
        for (int n = 0; n < 400; n++) begin
            if (n % 16 == 0) begin
                pt4_mux      = CELLS'($urandom);
                pt4_func_mux = CELLS'($urandom);
                ff_mode      = (2*CELLS)'($urandom);
            end
            ce = CELLS'($urandom);
            d  = CELLS'($urandom);
            sp = CELLS'($urandom & $urandom & $urandom);
            if (n % 97 == 50) begin
                ar = 1'b1; m_reset();
            end else if (n % 97 == 52) begin
                ar = 1'b0;
            end
            cycle("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
